// File: rtl/game_screen_ctrl_pkg.sv
// Shared types and constants for the game-flow controller: screen states,
// screen-select encodings and pixel colour widths.
package game_pkg;

    localparam int COLOR_W = 4;
    localparam int RGB_W   = 3 * COLOR_W;

    localparam logic [1:0] SCREEN_ATTRACT = 2'd0;
    localparam logic [1:0] SCREEN_PLAY    = 2'd1;
    localparam logic [1:0] SCREEN_OVER    = 2'd2;

    // State encodings equal the screen_sel codes so the state drives the mux directly.
    typedef enum logic [1:0] {
        ATTRACT = SCREEN_ATTRACT,
        PLAY    = SCREEN_PLAY,
        OVER    = SCREEN_OVER
    } state_e;

endpackage

// File: rtl/game_screen_ctrl_if.sv
// Renderer/VGA-side signal bundle of the game-flow controller.
// The controller takes the slave view; the surrounding pipeline takes master.
interface game_screen_ctrl_if;
    import game_pkg::*;

    logic               frame_tick;
    logic               video_on;
    logic               start_btn;
    logic               collision;
    logic [RGB_W-1:0]   rgb_start;
    logic [RGB_W-1:0]   rgb_play;
    logic [RGB_W-1:0]   rgb_end;
    logic [1:0]         screen_sel;
    logic               game_run;
    logic               game_reset;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;

    modport master (
        output frame_tick, video_on, start_btn, collision,
        output rgb_start, rgb_play, rgb_end,
        input  screen_sel, game_run, game_reset, red, green, blue
    );

    modport slave (
        input  frame_tick, video_on, start_btn, collision,
        input  rgb_start, rgb_play, rgb_end,
        output screen_sel, game_run, game_reset, red, green, blue
    );

endinterface

// File: rtl/game_screen_ctrl_rise_detect.sv
// Registered rising-edge detector; RESET_VAL sets the assumed previous level
// so a level already high when reset releases does not count as an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous.
    always_ff @(posedge clk) begin
        if (rst) prev_q <= RESET_VAL;
        else     prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/game_screen_ctrl.sv
// Game-flow controller: sequences attract/play/game-over screens on frame
// boundaries and registers the pixel colour of the selected renderer.
module game_screen_ctrl
    import game_pkg::*;
#(
    parameter int HOLD_FRAMES = 120,
    parameter int CNT_W       = 8
) (
    input  logic               clk_d,
    input  logic               rst,
    game_screen_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_FRAMES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               start_req_q, start_req_d;
    logic               hit_q, hit_d;
    logic               game_reset_q, game_reset_d;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic               start_rise;
    logic               start_eff;
    logic               hit_eff;

    rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
        .clk    (clk_d),
        .rst    (rst),
        .d_i    (bus.start_btn),
        .rise_o (start_rise)
    );

    // Requests seen in the tick cycle itself still count for that tick.
    assign start_eff = start_req_q | start_rise;
    assign hit_eff   = hit_q | ((state_q == PLAY) & bus.collision & bus.video_on);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        game_reset_d = 1'b0;
        start_req_d  = bus.frame_tick ? 1'b0 : start_eff;
        hit_d        = bus.frame_tick ? 1'b0 : hit_eff;

        if (bus.frame_tick) begin
            unique case (state_q)
                ATTRACT: begin
                    if (start_eff) begin
                        state_d      = PLAY;
                        game_reset_d = 1'b1;
                    end
                end
                PLAY: begin
                    if (hit_eff) begin
                        state_d = OVER;
                        hold_d  = HOLD_INIT;
                    end
                end
                OVER: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - CNT_W'(1);
                    end else if (start_eff) begin
                        state_d      = PLAY;
                        game_reset_d = 1'b1;
                    end
                end
                default: state_d = ATTRACT;
            endcase
        end

        // Mux uses the screen in effect before this edge.
        rgb_d = '0;
        if (bus.video_on) begin
            unique case (state_q)
                PLAY:    rgb_d = bus.rgb_play;
                OVER:    rgb_d = bus.rgb_end;
                default: rgb_d = bus.rgb_start;
            endcase
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state_q      <= ATTRACT;
            hold_q       <= '0;
            start_req_q  <= 1'b0;
            hit_q        <= 1'b0;
            game_reset_q <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            start_req_q  <= start_req_d;
            hit_q        <= hit_d;
            game_reset_q <= game_reset_d;
            rgb_q        <= rgb_d;
        end
    end

    assign bus.screen_sel = state_q;
    assign bus.game_run   = (state_q == PLAY);
    assign bus.game_reset = game_reset_q;
    assign bus.red        = rgb_q[RGB_W-1 -: COLOR_W];
    assign bus.green      = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue       = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Self-checking bench for game_screen_ctrl: directed flow sequences, a pixel
// mux vector table and randomized frames against a frame-level reference model.
module tb_game_screen_ctrl;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    game_screen_ctrl_if bus_if ();

    game_screen_ctrl #(.HOLD_FRAMES(HOLD), .CNT_W(8)) dut (
        .clk_d (clk),
        .rst   (rst),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model: screen as an integer, frame-accumulated request flags.
    int         m_screen;
    int         m_frames_left;
    bit         m_btn_prev;
    bit         m_pressed;
    bit         m_hit;
    bit         m_greset;
    logic [11:0] m_rgb;

    logic [11:0] cur_s, cur_p, cur_e;
    logic        btn_lvl;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit tk, input bit bt, input bit co, input bit vo);
        bit go_start, go_hit, rise;
        logic [11:0] src;
        if (r) begin
            m_screen = 0; m_frames_left = 0; m_btn_prev = 1'b1;
            m_pressed = 1'b0; m_hit = 1'b0; m_greset = 1'b0; m_rgb = '0;
            return;
        end
        src      = (m_screen == 1) ? cur_p : (m_screen == 2) ? cur_e : cur_s;
        m_rgb    = vo ? src : 12'h000;
        rise     = bt && !m_btn_prev;
        go_start = m_pressed || rise;
        go_hit   = m_hit || (m_screen == 1 && co && vo);
        m_greset = 1'b0;
        if (tk) begin
            if (m_screen == 0 && go_start) begin
                m_screen = 1; m_greset = 1'b1;
            end else if (m_screen == 1 && go_hit) begin
                m_screen = 2; m_frames_left = HOLD;
            end else if (m_screen == 2) begin
                if (m_frames_left > 0) m_frames_left--;
                else if (go_start) begin
                    m_screen = 1; m_greset = 1'b1;
                end
            end
            m_pressed = 1'b0;
            m_hit     = 1'b0;
        end else begin
            m_pressed = go_start;
            m_hit     = go_hit;
        end
        m_btn_prev = bt;
    endtask

    // One clock: drive, let the edge happen, update model, compare after settling.
    task automatic cyc(input bit r, input bit tk, input bit co, input bit vo);
        rst                 = r;
        bus_if.frame_tick   = tk;
        bus_if.start_btn    = btn_lvl;
        bus_if.collision    = co;
        bus_if.video_on     = vo;
        bus_if.rgb_start    = cur_s;
        bus_if.rgb_play     = cur_p;
        bus_if.rgb_end      = cur_e;
        @(posedge clk);
        model_edge(r, tk, btn_lvl, co, vo);
        #1;
        check("screen_sel", 32'(bus_if.screen_sel), 32'(m_screen));
        check("game_run",   32'(bus_if.game_run),   32'(m_screen == 1));
        check("game_reset", 32'(bus_if.game_reset), 32'(m_greset));
        check("rgb", 32'({bus_if.red, bus_if.green, bus_if.blue}), 32'(m_rgb));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press();
        btn_lvl = 1'b0; idle(3);
        btn_lvl = 1'b1; idle(3);
    endtask

    typedef struct {
        logic        von;
        logic [11:0] s, p, e;
        logic [11:0] exp_a, exp_p, exp_o;
    } pix_vec_t;

    pix_vec_t vecs[5];

    task automatic run_pix_table(input int screen);
        logic [11:0] exp;
        for (int i = 0; i < 5; i++) begin
            cur_s = vecs[i].s; cur_p = vecs[i].p; cur_e = vecs[i].e;
            cyc(1'b0, 1'b0, 1'b0, vecs[i].von);
            exp = (screen == 1) ? vecs[i].exp_p : (screen == 2) ? vecs[i].exp_o : vecs[i].exp_a;
            check("pix_table", 32'({bus_if.red, bus_if.green, bus_if.blue}), 32'(exp));
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'hABC, 12'h123, 12'hF0F, 12'hABC, 12'h123, 12'hF0F};
        vecs[1] = '{1'b0, 12'hABC, 12'h123, 12'hF0F, 12'h000, 12'h000, 12'h000};
        vecs[2] = '{1'b1, 12'hFFF, 12'h000, 12'h555, 12'hFFF, 12'h000, 12'h555};
        vecs[3] = '{1'b1, 12'h001, 12'h800, 12'h0F0, 12'h001, 12'h800, 12'h0F0};
        vecs[4] = '{1'b0, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000};

        cur_s = 12'hABC; cur_p = 12'h123; cur_e = 12'hF0F;
        btn_lvl = 1'b1;

        // Reset with the button held: no start afterwards.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("reset_screen", 32'(bus_if.screen_sel), 32'd0);
        check("reset_rgb", 32'({bus_if.red, bus_if.green, bus_if.blue}), 32'd0);
        idle(10); tick();
        check("held_btn_no_start", 32'(bus_if.screen_sel), 32'd0);
        press();
        check("press_waits_tick", 32'(bus_if.screen_sel), 32'd0);
        idle(20); tick();
        check("start_screen", 32'(bus_if.screen_sel), 32'd1);
        check("start_run", 32'(bus_if.game_run), 32'd1);
        check("start_greset", 32'(bus_if.game_reset), 32'd1);
        idle(1);
        check("greset_one_cycle", 32'(bus_if.game_reset), 32'd0);

        // Collision in blanking is ignored; visible collision ends the game.
        cyc(1'b0, 1'b0, 1'b1, 1'b0); idle(5); tick();
        check("blank_hit_ignored", 32'(bus_if.screen_sel), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1); idle(5); tick();
        check("hit_to_over", 32'(bus_if.screen_sel), 32'd2);
        check("over_run_low", 32'(bus_if.game_run), 32'd0);

        // Presses during the hold are discarded.
        for (int f = 1; f <= 3; f++) begin
            press(); tick();
            check("hold_press_ignored", 32'(bus_if.screen_sel), 32'd2);
        end
        idle(5); tick();
        check("hold_tick4", 32'(bus_if.screen_sel), 32'd2);
        press(); tick();
        check("restart_screen", 32'(bus_if.screen_sel), 32'd1);
        check("restart_greset", 32'(bus_if.game_reset), 32'd1);

        // Start edge, collision and tick in one cycle: collision wins.
        btn_lvl = 1'b0; idle(5);
        btn_lvl = 1'b1; cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("coll_beats_start", 32'(bus_if.screen_sel), 32'd2);
        check("coll_no_greset", 32'(bus_if.game_reset), 32'd0);
        for (int f = 0; f < HOLD; f++) begin idle(5); tick(); end
        idle(5); tick();
        check("start_req_cleared", 32'(bus_if.screen_sel), 32'd2);

        // Reset mid-hold returns to attract with no game_reset.
        press(); tick();
        cyc(1'b0, 1'b0, 1'b1, 1'b1); tick();
        idle(3); tick(); idle(3); tick();
        check("pre_reset_over", 32'(bus_if.screen_sel), 32'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_screen", 32'(bus_if.screen_sel), 32'd0);
        check("rst_run", 32'(bus_if.game_run), 32'd0);
        check("rst_greset", 32'(bus_if.game_reset), 32'd0);
        check("rst_rgb", 32'({bus_if.red, bus_if.green, bus_if.blue}), 32'd0);

        // Pixel mux table in each screen.
        btn_lvl = 1'b1;
        run_pix_table(0);
        press(); tick(); idle(2);
        run_pix_table(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1); tick(); idle(2);
        run_pix_table(2);

        // Randomized frames against the reference model.
        for (int c = 0; c < 6000; c++) begin
            bit r, tk, co, vo;
            cur_s = 12'($urandom); cur_p = 12'($urandom); cur_e = 12'($urandom);
            if ($urandom_range(0, 29) == 0) btn_lvl = ~btn_lvl;
            r  = ($urandom_range(0, 999) == 0);
            tk = ((c % 100) == 99);
            vo = ((c % 100) < 80);
            co = ($urandom_range(0, 149) == 0);
            cyc(r, tk, co, vo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
